mem_read_sched: RTL and testbench

Read-side scheduler for the Mannix SRAM memory farm. It arbitrates the five accelerator read clients (fcc, active, cnn_pic, cnn_wgt, pool) for the single farm read path. It issues each granted burst as a sequence of row addresses with a valid/ready handshake, and signals completion back to the client. It sits between the client `mem_intf_read` request side and the farm controller's SRAM address/read-enable path, and is driven by the same `client_priority` vector the farm receives.

---
 rtl/mem_read_sched.sv | 144 ++++++++++++++
 tb/tb_mem_read_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_sched.sv
// rtl/mem_read_sched.sv - read-side burst scheduler for the SRAM farm read path
module mem_read_sched #(
    parameter int NUM_CLIENTS = 5,
    parameter int ADDR_W      = 19,
    parameter int LEN_W       = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CLIENTS-1:0]              req,
    input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_CLIENTS-1:0][LEN_W-1:0]   req_len,
    input  logic [NUM_CLIENTS-1:0]              client_priority,
    output logic [NUM_CLIENTS-1:0]              gnt,
    output logic                                sram_req,
    output logic [ADDR_W-1:0]                   sram_addr,
    output logic [2:0]                          sram_client,
    output logic                                sram_last,
    input  logic                                sram_ready,
    output logic [NUM_CLIENTS-1:0]              done,
    output logic                                busy
);

    // Client index width is fixed by the sram_client port.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]  base_q,   base_d;
    logic [LEN_W-1:0]   last_q,   last_d;     // index of the final beat (effective length - 1)
    logic [LEN_W-1:0]   cnt_q,    cnt_d;

    logic [NUM_CLIENTS-1:0] cand;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    int                     probe;

    logic                   in_burst;
    logic                   in_done;
    logic                   beat_is_last;
    logic [NUM_CLIENTS-1:0] winner_onehot;

    // Winner selection: high-priority class masks out normal clients when any
    // of them is requesting; round-robin search starts just past rr_ptr.
    always_comb begin
        cand      = req & client_priority;
        win_idx   = '0;
        win_found = 1'b0;
        probe     = 0;
        if (cand == '0) begin
            cand = req;
        end
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            probe = (int'(rr_ptr_q) + i) % NUM_CLIENTS;
            if (!win_found && cand[probe]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(probe);
            end
        end
    end

    // State and burst-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            rr_ptr_q <= IDX_W'(NUM_CLIENTS - 1);
            base_q   <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            base_q   <= base_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: inputs are only sampled in IDLE, so a burst runs to
    // completion no matter what the requester does afterwards.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_ptr_d = rr_ptr_q;
        base_d   = base_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_BURST;
                    winner_d = win_idx;
                    rr_ptr_d = win_idx;
                    base_d   = req_addr[win_idx];
                    // A zero length is issued as a single beat.
                    last_d   = (req_len[win_idx] == '0) ? '0
                                                        : req_len[win_idx] - LEN_W'(1);
                    cnt_d    = '0;
                end
            end
            ST_BURST: begin
                if (sram_ready) begin
                    if (cnt_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only; sram_ready never reaches here.
    always_comb begin
        in_burst      = (state_q == ST_BURST);
        in_done       = (state_q == ST_DONE);
        beat_is_last  = (cnt_q == last_q);
        winner_onehot = NUM_CLIENTS'(1) << winner_q;

        gnt         = in_burst ? winner_onehot : '0;
        done        = in_done  ? winner_onehot : '0;
        sram_req    = in_burst;
        sram_last   = in_burst && beat_is_last;
        // Row address wraps naturally at 2^ADDR_W.
        sram_addr   = in_burst ? (base_q + ADDR_W'(cnt_q)) : '0;
        sram_client = in_burst ? winner_q : '0;
        busy        = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_read_sched.sv
// tb/tb_mem_read_sched.sv - self-checking bench for mem_read_sched
module tb_mem_read_sched;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       req;
    logic [4:0][18:0] req_addr;
    logic [4:0][7:0]  req_len;
    logic [4:0]       client_priority;
    logic             sram_ready;
    logic [4:0]       gnt;
    logic             sram_req;
    logic [18:0]      sram_addr;
    logic [2:0]       sram_client;
    logic             sram_last;
    logic [4:0]       done;
    logic             busy;

    int tests = 0;
    int fails = 0;

    mem_read_sched #(.NUM_CLIENTS(5), .ADDR_W(19), .LEN_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .client_priority (client_priority),
        .gnt             (gnt),
        .sram_req        (sram_req),
        .sram_addr       (sram_addr),
        .sram_client     (sram_client),
        .sram_last       (sram_last),
        .sram_ready      (sram_ready),
        .done            (done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " gnt"},         32'(gnt),         32'd0);
        check({tag, " sram_req"},    32'(sram_req),    32'd0);
        check({tag, " sram_addr"},   32'(sram_addr),   32'd0);
        check({tag, " sram_client"}, 32'(sram_client), 32'd0);
        check({tag, " sram_last"},   32'(sram_last),   32'd0);
        check({tag, " done"},        32'(done),        32'd0);
        check({tag, " busy"},        32'(busy),        32'd0);
    endtask

    typedef struct {
        int          client;
        logic [18:0] addr;
        logic [7:0]  len;
        int          exp_beats;
        logic [18:0] exp_final;
    } vec_t;

    vec_t vecs[4];

    // Single-requester burst with sram_ready high; starts and ends at a negedge in IDLE.
    task automatic run_burst(input vec_t v);
        logic [18:0] exp_addr;
        req = '0;
        req[v.client]      = 1'b1;
        req_addr[v.client] = v.addr;
        req_len[v.client]  = v.len;
        check("pre busy", 32'(busy), 32'd0);
        @(negedge clk);
        req = '0;
        for (int b = 0; b < v.exp_beats; b++) begin
            exp_addr = v.addr + 19'(b);
            check("burst gnt",    32'(gnt),         32'(1) << v.client);
            check("burst req",    32'(sram_req),    32'd1);
            check("burst addr",   32'(sram_addr),   32'(exp_addr));
            check("burst client", 32'(sram_client), 32'(v.client));
            check("burst last",   32'(sram_last),   32'(b == v.exp_beats - 1));
            check("burst done",   32'(done),        32'd0);
            if (b == v.exp_beats - 1)
                check("final addr", 32'(sram_addr), 32'(v.exp_final));
            @(negedge clk);
        end
        check("done pulse",    32'(done),     32'(1) << v.client);
        check("done gnt",      32'(gnt),      32'd0);
        check("done sram_req", 32'(sram_req), 32'd0);
        check("done last",     32'(sram_last),32'd0);
        check("done busy",     32'(busy),     32'd1);
        @(negedge clk);
        check("post done", 32'(done), 32'd0);
        check("post busy", 32'(busy), 32'd0);
    endtask

    // Len-1 burst with continuous requests: BURST, DONE, IDLE then the next grant.
    task automatic rr_step(input int c);
        check("rr gnt",    32'(gnt),         32'(1) << c);
        check("rr client", 32'(sram_client), 32'(c));
        @(negedge clk);
        check("rr done",   32'(done),        32'(1) << c);
        check("rr gnt0",   32'(gnt),         32'd0);
        @(negedge clk);
        check("rr bubble", 32'(busy),        32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic       bp_ready[7];
    logic [1:0] bp_off[7];
    logic       bp_last[7];

    initial begin
        vecs[0] = '{2, 19'h00100, 8'd3, 3, 19'h00102};
        vecs[1] = '{1, 19'h7FFFE, 8'd4, 4, 19'h00001};
        vecs[2] = '{4, 19'h12345, 8'd0, 1, 19'h12345};
        vecs[3] = '{0, 19'h7FFFF, 8'd1, 1, 19'h7FFFF};

        bp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bp_off   = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        bp_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n           = 1'b0;
        req             = '0;
        req_addr        = '0;
        req_len         = '0;
        client_priority = '0;
        sram_ready      = 1'b1;
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        // Table-driven single bursts: basic, wrap, len 0, len 1 at top of range.
        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i]);
        end

        // Pure round-robin from reset, then priority class.
        do_reset();
        req             = 5'h1F;
        req_len         = {5{8'd1}};
        client_priority = '0;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            rr_step(k % 5);
        end
        client_priority = 5'b01000;
        rr_step(2);
        rr_step(3);
        rr_step(3);
        req[3] = 1'b0;
        rr_step(3);
        rr_step(4);
        rr_step(0);
        req = '0;
        rr_step(1);
        check("rr end busy", 32'(busy), 32'd0);
        client_priority = '0;

        // Backpressure on a 4-beat burst.
        req         = 5'b00001;
        req_addr[0] = 19'h00200;
        req_len[0]  = 8'd4;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 7; i++) begin
            check("bp addr", 32'(sram_addr), 32'(19'h00200 + 19'(bp_off[i])));
            check("bp last", 32'(sram_last), 32'(bp_last[i]));
            check("bp done", 32'(done),      32'd0);
            sram_ready = bp_ready[i];
            @(negedge clk);
        end
        check("bp done pulse", 32'(done), 32'd1);
        sram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp no 2nd done", 32'(done), 32'd0);
            check("bp idle", 32'(busy), 32'd0);
        end
        sram_ready = 1'b1;

        // Reset in the middle of a client-3 burst.
        req         = 5'b01000;
        req_addr[3] = 19'h00300;
        req_len[3]  = 8'd4;
        @(negedge clk);
        req = '0;
        check("mid beat1 addr", 32'(sram_addr), 32'h300);
        @(negedge clk);
        check("mid beat2 addr", 32'(sram_addr), 32'h301);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst no done", 32'(done), 32'd0);
        end
        rst_n   = 1'b1;
        req     = 5'h1F;
        req_len = {5{8'd1}};
        @(negedge clk);
        check("post rst gnt", 32'(gnt), 32'd1);
        req = '0;
        @(negedge clk);
        check("post rst done", 32'(done), 32'd1);
        @(negedge clk);
        check("post rst idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
